// File: rtl/timed_chip.sv
// timed_chip: cycle-timed DRAM-like device model.
// Each bank tracks IDLE/ACTIVATING/ACTIVE/PRECHARGING with its own timer and
// open row. Column commands are spaced by TCCD. Reads return data after CL
// cycles through an in-order valid/data pipeline. Illegal commands are still
// accepted, change nothing and raise a one-cycle err pulse.
module timed_chip #(
    parameter int BGWIDTH      = 2,
    parameter int BAWIDTH      = 2,
    parameter int COLWIDTH     = 10,
    parameter int CHWIDTH      = 5,
    parameter int DEVICE_WIDTH = 4,
    parameter int TRCD         = 3,
    parameter int TRP          = 3,
    parameter int CL           = 4,
    parameter int TCCD         = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [2:0]                           cmd,
    input  logic [BGWIDTH-1:0]                   bg,
    input  logic [BAWIDTH-1:0]                   ba,
    input  logic [CHWIDTH-1:0]                   row,
    input  logic [COLWIDTH-1:0]                  column,
    input  logic [DEVICE_WIDTH-1:0]              dqin,
    output logic [DEVICE_WIDTH-1:0]              dqout,
    output logic                                 dqout_valid,
    output logic                                 err,
    output logic [2**(BGWIDTH+BAWIDTH)-1:0]      bank_open
);

    localparam int BKW  = BGWIDTH + BAWIDTH;
    localparam int NB   = 2 ** BKW;
    localparam int AW   = BKW + CHWIDTH + COLWIDTH;
    localparam int MAXT = (TRCD > TRP) ? ((TRCD > TCCD) ? TRCD : TCCD)
                                       : ((TRP > TCCD) ? TRP : TCCD);
    localparam int CNTW = (MAXT > 1) ? $clog2(MAXT) : 1;

    // Timers count down to zero; a bank leaves its transient state on the edge
    // where its timer is already zero, so the load value is delay-2 (the
    // accepting edge itself and the exiting edge both count).
    localparam logic [CNTW-1:0] TRCD_LD = CNTW'((TRCD > 1) ? TRCD - 2 : 0);
    localparam logic [CNTW-1:0] TRP_LD  = CNTW'((TRP > 1) ? TRP - 2 : 0);
    localparam logic [CNTW-1:0] TCCD_LD = CNTW'(TCCD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVATING,
        ST_ACTIVE,
        ST_PRECHARGING
    } bank_state_e;

    bank_state_e               state_q [NB];
    bank_state_e               state_d [NB];
    logic [CNTW-1:0]           cnt_q   [NB];
    logic [CNTW-1:0]           cnt_d   [NB];
    logic [CHWIDTH-1:0]        row_q   [NB];
    logic [CNTW-1:0]           tccd_q, tccd_d;
    logic                      err_q, err_d;
    logic [CL-1:0]             vld_q, vld_d;
    logic [DEVICE_WIDTH-1:0]   data_q  [CL];
    logic [DEVICE_WIDTH-1:0]   data_d  [CL];
    logic [DEVICE_WIDTH-1:0]   mem_q   [2**AW];

    logic [BKW-1:0]            bank_sel;
    bank_state_e               sel_state;
    logic                      cmd_acc;
    logic                      is_act, is_rd, is_wr, is_pre;
    logic                      act_ok, col_ok, pre_ok, legal;
    logic                      do_act, do_rd, do_wr, do_close;
    logic [AW-1:0]             mem_addr;
    logic [DEVICE_WIDTH-1:0]   rd_data;

    assign bank_sel  = {bg, ba};
    assign sel_state = state_q[bank_sel];
    assign cmd_ready = (tccd_q == '0);
    assign cmd_acc   = cmd_valid && cmd_ready;

    assign is_act = (cmd == 3'd1);
    assign is_rd  = (cmd == 3'd2);
    assign is_wr  = (cmd == 3'd3);
    assign is_pre = (cmd == 3'd4);

    // Legality uses only the registered bank state, never the counter.
    assign act_ok = is_act && (sel_state == ST_IDLE);
    assign col_ok = (is_rd || is_wr) && (sel_state == ST_ACTIVE);
    assign pre_ok = is_pre && ((sel_state == ST_IDLE) || (sel_state == ST_ACTIVE));
    assign legal  = act_ok || col_ok || pre_ok;

    assign do_act   = cmd_acc && act_ok;
    assign do_rd    = cmd_acc && is_rd && col_ok;
    assign do_wr    = cmd_acc && is_wr && col_ok;
    assign do_close = cmd_acc && is_pre && (sel_state == ST_ACTIVE);

    assign mem_addr = {bg, ba, row_q[bank_sel], column};
    assign rd_data  = mem_q[mem_addr];

    assign dqout_valid = vld_q[CL-1];
    assign dqout       = data_q[CL-1];
    assign err         = err_q;

    // Per-bank next state: timers run in every bank, the command hits one bank.
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            state_d[b] = state_q[b];
            cnt_d[b]   = cnt_q[b];
            case (state_q[b])
                ST_ACTIVATING: begin
                    if (cnt_q[b] == '0) state_d[b] = ST_ACTIVE;
                    else                cnt_d[b]   = cnt_q[b] - CNTW'(1);
                end
                ST_PRECHARGING: begin
                    if (cnt_q[b] == '0) state_d[b] = ST_IDLE;
                    else                cnt_d[b]   = cnt_q[b] - CNTW'(1);
                end
                default: ;
            endcase
            if (bank_sel == BKW'(b)) begin
                if (do_act) begin
                    state_d[b] = (TRCD > 1) ? ST_ACTIVATING : ST_ACTIVE;
                    cnt_d[b]   = TRCD_LD;
                end
                if (do_close) begin
                    state_d[b] = (TRP > 1) ? ST_PRECHARGING : ST_IDLE;
                    cnt_d[b]   = TRP_LD;
                end
            end
        end
    end

    // Column spacing, error pulse and the read-return pipeline.
    always_comb begin
        tccd_d = tccd_q;
        if (do_rd || do_wr)      tccd_d = TCCD_LD;
        else if (tccd_q != '0)   tccd_d = tccd_q - CNTW'(1);
        err_d     = cmd_acc && (is_act || is_rd || is_wr || is_pre) && !legal;
        vld_d     = '0;
        vld_d[0]  = do_rd;
        data_d[0] = do_rd ? rd_data : data_q[0];
        // Stages only take new data when a valid word moves in, so the last
        // stage holds the previous read value between strobes.
        for (int i = 1; i < CL; i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = vld_q[i-1] ? data_q[i-1] : data_q[i];
        end
    end

    // Bank-open flags straight from the registered states.
    always_comb begin
        bank_open = '0;
        for (int b = 0; b < NB; b++) begin
            bank_open[b] = (state_q[b] == ST_ACTIVE);
        end
    end

    // Control and output registers; reset wipes all in-flight reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                state_q[b] <= ST_IDLE;
                cnt_q[b]   <= '0;
            end
            tccd_q <= '0;
            err_q  <= 1'b0;
            vld_q  <= '0;
            for (int i = 0; i < CL; i++) data_q[i] <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                state_q[b] <= state_d[b];
                cnt_q[b]   <= cnt_d[b];
            end
            tccd_q <= tccd_d;
            err_q  <= err_d;
            vld_q  <= vld_d;
            for (int i = 0; i < CL; i++) data_q[i] <= data_d[i];
        end
    end

    // Open-row latches and array storage survive reset.
    always_ff @(posedge clk) begin
        if (do_act) row_q[bank_sel] <= row;
        if (do_wr)  mem_q[mem_addr] <= dqin;
    end

endmodule

// File: doc/timed_chip.md
TIMED_CHIP -- requirements
Module: timed_chip

Interface
REQ-001 SHALL have parameter BGWIDTH, default 2, meaning log2 of the bank-group count.
REQ-002 SHALL have parameter BAWIDTH, default 2, meaning log2 of the banks per group.
REQ-003 SHALL have parameter COLWIDTH, default 10, meaning column address width.
REQ-004 SHALL have parameter CHWIDTH, default 5, meaning row address width.
REQ-005 SHALL have parameter DEVICE_WIDTH, default 4, meaning data word width.
REQ-006 SHALL have parameter TRCD, default 3, meaning ACT-to-column-command delay in cycles (>=1).
REQ-007 SHALL have parameter TRP, default 3, meaning PRE-to-idle delay in cycles (>=1).
REQ-008 SHALL have parameter CL, default 4, meaning RD-to-data latency in cycles (>=1).
REQ-009 SHALL have parameter TCCD, default 2, meaning minimum spacing between column commands in cycles (>=1).
REQ-010 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-011 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-012 SHALL have port cmd_valid, input, 1, meaning a command is presented.
REQ-013 SHALL have port cmd_ready, output, 1, meaning a command can be accepted this cycle.
REQ-014 SHALL have port cmd, input, 3, with encoding 0=NOP, 1=ACT, 2=RD, 3=WR, 4=PRE; codes 5-7 are treated as NOP.
REQ-015 SHALL have ports bg (BGWIDTH), ba (BAWIDTH), row (CHWIDTH), column (COLWIDTH) and dqin (DEVICE_WIDTH), all inputs carrying the command fields.
REQ-016 SHALL have port dqout, output, DEVICE_WIDTH, carrying read data.
REQ-017 SHALL have port dqout_valid, output, 1, a one-cycle read-data strobe.
REQ-018 SHALL have port err, output, 1, a one-cycle illegal-command pulse.
REQ-019 SHALL have port bank_open, output, 2**(BGWIDTH+BAWIDTH), where bit {bg,ba} is high when that bank is ACTIVE.

Function
REQ-020 SHALL treat a command as accepted at a rising edge where cmd_valid && cmd_ready.
REQ-021 SHALL keep, for each bank, an FSM with states IDLE, ACTIVATING, ACTIVE and PRECHARGING, plus an open-row register and a down-counter.
REQ-022 SHALL, on ACT accepted at cycle T to an IDLE bank, latch row, enter ACTIVATING and enter ACTIVE at T+TRCD; a column command accepted at T+TRCD is legal, at T+TRCD-1 illegal.
REQ-023 SHALL, on PRE accepted at T to an ACTIVE bank, enter PRECHARGING and enter IDLE at T+TRP.
REQ-024 SHALL treat PRE to an IDLE bank as a legal no-op.
REQ-025 SHALL, on WR accepted to an ACTIVE bank, write dqin to storage[bg][ba][open row][column] at that edge.
REQ-026 SHALL, on RD accepted at T to an ACTIVE bank, read storage[bg][ba][open row][column] and present it on dqout with dqout_valid high during cycle T+CL only.
REQ-027 SHALL use a CL-deep valid/data pipeline so that back-to-back reads produce back-to-back strobes in order.
REQ-028 SHALL return the written value for a RD to the same address accepted one cycle after a WR.
REQ-029 SHALL hold dqout at its last value when dqout_valid is low.
REQ-030 SHALL deassert cmd_ready in cycles T+1..T+TCCD-1 after a RD/WR accepted at T; TCCD=1 keeps cmd_ready high.
REQ-031 SHALL treat ACT to a non-IDLE bank as illegal.
REQ-032 SHALL treat RD or WR to a non-ACTIVE bank as illegal.
REQ-033 SHALL treat PRE to an ACTIVATING or PRECHARGING bank as illegal.
REQ-034 SHALL handle an illegal command by accepting it, pulsing err high in the cycle after acceptance, and changing no state, storage or pipeline.
REQ-035 SHALL evaluate legality against the bank state at the start of the cycle; a counter expiring on the same edge does not make the command legal.
REQ-036 SHALL affect only the addressed bank with any command; other banks' counters continue independently.
REQ-037 SHALL accept NOP without changing state, and NOP does not consume TCCD.

Reset
REQ-038 SHALL, while rst is high, force all banks to IDLE, clear counters and pipeline, and drive dqout=0, dqout_valid=0, err=0, bank_open=0 and cmd_ready=1.
REQ-039 SHALL, when rst is asserted mid-operation, discard in-flight reads with no dqout_valid pulse.
REQ-040 SHALL leave storage contents unaffected by reset.

Verification
REQ-041 SHALL cover: ACT bg=1 ba=2 row=5 at T0, WR col=7 dqin=0xA at T0+3, RD col=7 at T0+5 -> dqout=0xA with dqout_valid high at T0+9 only; bank_open bit 6 high from T0+3.
REQ-042 SHALL cover: ACT at T0, RD to the same bank at T0+2 -> err high at T0+3, no dqout_valid.
REQ-043 SHALL cover: two RDs, the second accepted 2 cycles after the first, with TCCD=2 -> cmd_ready low for exactly 1 cycle between them, and two strobes 2 cycles apart in issue order.
REQ-044 SHALL cover: PRE at T0 then ACT at T0+2 (illegal, err) and ACT at T0+3 (legal) -> bank ACTIVE at T0+6.
REQ-045 SHALL cover: RD accepted, then rst pulsed 2 cycles later -> no strobe, all outputs at reset values, and a re-opened row still returns the previously written data.
REQ-046 SHALL cover: ACT to banks 0 and 15 in consecutive cycles -> each bank becomes ACTIVE at its own T+TRCD independently.
